msk_sbox_col_seq: RTL and testbench
===================================

Name: msk_sbox_col_seq

Overview:
- Sequencer that pushes one masked 4-byte column through a single shared masked S-box datapath.
- The datapath is the forward/inverse first layer, muxes, pipelined common core and forward/inverse second layer, with fixed latency SBOX_LAT.
- The block accepts a column over a valid/ready handshake, issues one byte per cycle gated on fresh randomness, tags bytes in flight, reassembles the results, and presents the column over a valid/ready output handshake.
- It also drives the datapath's inverse select and the PRNG ready, and flags randomness starvation while data is in flight.

Parameters:
- d, 2, number of shares per bit.
- SBOX_LAT, 4, cycles from a byte on sbox_in to its result on sbox_out; must be ≥1.
- NBYTES, 4, bytes per column.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  column offered.
- in_ready  out  1  column accepted when in_valid&in_ready.
- in_inverse  in  1  1 = inverse S-box for this column; sampled at acceptance.
- in_data  in  8*d*NBYTES  masked column; byte k at [8*d*k +: 8*d], bit j of a byte at [d*j +: d].
- sbox_in  out  8*d  masked byte to datapath; all zero when sbox_in_valid=0.
- sbox_in_valid  out  1  sbox_in carries a live byte this cycle.
- sbox_inverse  out  1  inverse select to all datapath muxes.
- sbox_out  in  8*d  datapath result.
- rnd_valid  in  1  PRNG has fresh randomness for this cycle.
- rnd_ready  out  1  randomness consumed this cycle.
- out_valid  out  1  result column available.
- out_ready  in  1  consumer accepts.
- out_data  out  8*d*NBYTES  result column, same layout as in_data.
- rnd_err  out  1  sticky starvation flag.

Behaviour:
- States: IDLE, ISSUE, DRAIN, OUT. Reset → IDLE.
- Reset values: in_ready=1 in IDLE after reset; out_valid=0, sbox_in_valid=0, rnd_ready=0, rnd_err=0, sbox_inverse=0, out_data=0. All tags cleared, issue counter 0.
- IDLE:
  - in_ready=1.
  - On handshake, latch in_data and in_inverse into a column register and go to ISSUE next cycle.
- ISSUE:
  - Each cycle with rnd_valid=1, drive byte[cnt] on sbox_in with sbox_in_valid=1, push tag {valid, cnt} into a SBOX_LAT-deep tag shift register, and increment cnt.
  - A cycle with rnd_valid=0 issues nothing; this is a stall.
  - After byte NBYTES-1 is issued, go to DRAIN.
- Tag capture: when the tag exiting the shift register is valid, capture sbox_out into out_data slot tag.idx. This occurs exactly SBOX_LAT cycles after issue.
- DRAIN: when the last valid tag has been captured, go to OUT. out_valid rises the cycle after the last capture.
- OUT:
  - out_valid=1; out_data stable.
  - On out_valid&out_ready, go to IDLE; in_ready=1 from the next cycle. in_ready is never combinational on out_ready.
  - No new column is accepted before the output is drained.
- sbox_inverse:
  - Equals the latched in_inverse from acceptance through the end of DRAIN.
  - Held constant while any tag is valid.
- rnd_ready = sbox_in_valid OR any tag valid in stages 0..SBOX_LAT-2. Every pipeline stage holding live data consumes fresh randomness each cycle.
- rnd_err:
  - Set when any tag is valid and rnd_valid=0. In-flight data has advanced without fresh masks.
  - A stall in ISSUE with no tags valid is legal and does not set it.
  - Cleared only by rst.
- Nominal latency with continuous rnd_valid:
  - Acceptance at edge 0.
  - Issues in cycles 1..NBYTES.
  - out_valid in cycle NBYTES+SBOX_LAT+1 (9 at defaults).
- Reset mid-operation clears tags, so late results leaving the datapath are ignored. The first handshake after reset behaves as from power-up.
- in_valid high in ISSUE, DRAIN or OUT is ignored; in_data need not be held.

Test Plan:
- Bench uses a behavioral S-box model with latency SBOX_LAT=4, d=2, share1 = plain byte, share0 = 0, and rnd_valid=1.
  - Forward column 00,01,53,12 → out bytes 63,7c,ed,c9; out_valid in cycle 9; sbox_inverse=0.
- Inverse column 63,7c,ed,12 → 00,01,53,39; sbox_inverse=1 cycles 1–8. Repeat with random share0 masks; the recombined result must be identical.
- rnd_valid=0 for cycles 1–3, then 1 → issues in cycles 4–7, out_valid in cycle 12, rnd_err=0.
- rnd_valid dropped in cycle 3 (two tags in flight) → rnd_err=1 from cycle 4 and stays 1 after the column completes, until rst.
- out_ready low for 10 cycles in OUT → out_valid and out_data stable, in_ready=0, in_valid ignored. out_ready=1 → IDLE, in_ready=1 the next cycle.
- rst asserted in cycle 3 → all outputs at reset values next cycle, no out_valid from stale results. A new column accepted immediately after completes normally.

Source files
------------

// File: rtl/msk_sbox_col_seq.sv
// ----------------------------------------------------------------------------
// msk_sbox_col_seq
//   Pushes one masked column of NBYTES bytes through a single shared masked
//   S-box datapath of fixed latency SBOX_LAT. A byte is issued only in a cycle
//   with fresh randomness. Each issued byte carries a tag {valid, idx} through
//   a SBOX_LAT-deep shift register. When the tag leaves that register, the
//   datapath result is written into output slot idx.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  column input handshake; in_inverse sampled at accept
//   in_data            masked column, byte k at [8*d*k +: 8*d]
//   sbox_in/_valid     byte to datapath (all zero when not valid)
//   sbox_inverse       inverse select for the datapath muxes
//   sbox_out           datapath result, SBOX_LAT cycles after sbox_in
//   rnd_valid          PRNG has fresh randomness for this cycle
//   rnd_ready          randomness consumed this cycle
//   out_valid/ready    column output handshake, out_data same layout as in_data
//   rnd_err            sticky: live data advanced without fresh randomness
// ----------------------------------------------------------------------------
module msk_sbox_col_seq #(
    parameter int d        = 2,
    parameter int SBOX_LAT = 4,
    parameter int NBYTES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_inverse,
    input  logic [8*d*NBYTES-1:0] in_data,
    output logic [8*d-1:0]        sbox_in,
    output logic                  sbox_in_valid,
    output logic                  sbox_inverse,
    input  logic [8*d-1:0]        sbox_out,
    input  logic                  rnd_valid,
    output logic                  rnd_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*d*NBYTES-1:0] out_data,
    output logic                  rnd_err
);

    localparam int BW   = 8 * d;
    localparam int CW   = BW * NBYTES;
    localparam int CNTW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic            inv_q, inv_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   out_data_q, out_data_d;
    logic            rnd_err_q, rnd_err_d;
    logic [SBOX_LAT-1:0] tag_v_q, tag_v_d;
    logic [CNTW-1:0] tag_idx_q [SBOX_LAT];
    logic [CNTW-1:0] tag_idx_d [SBOX_LAT];

    logic            issue_s;
    logic            up_busy_s;
    logic            capture_s;
    logic [BW-1:0]   sbox_in_s;

    // Issue decision and pipeline occupancy summary
    always_comb begin
        issue_s   = (state_q == ST_ISSUE) && rnd_valid;
        // Stages 0..SBOX_LAT-2 still hold data inside the datapath and need masks
        up_busy_s = 1'b0;
        for (int i = 0; i < SBOX_LAT - 1; i++) begin
            up_busy_s = up_busy_s | tag_v_q[i];
        end
        capture_s = tag_v_q[SBOX_LAT-1];
        if (issue_s) begin
            sbox_in_s = col_q[BW*int'(cnt_q) +: BW];
        end else begin
            sbox_in_s = {BW{1'b0}};
        end
    end

    // Tag shift register mirroring the datapath pipeline
    always_comb begin
        tag_v_d[0]   = issue_s;
        tag_idx_d[0] = cnt_q;
        for (int i = 1; i < SBOX_LAT; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    // Result capture into the output slot named by the exiting tag
    always_comb begin
        out_data_d = out_data_q;
        if (capture_s) begin
            out_data_d[BW*int'(tag_idx_q[SBOX_LAT-1]) +: BW] = sbox_out;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Starvation flag: live tags moved on in a cycle without fresh masks
    always_comb begin
        if ((|tag_v_q) && !rnd_valid) begin
            rnd_err_d = 1'b1;
        end else begin
            rnd_err_d = rnd_err_q;
        end
    end

    // Sequencer next-state and registered handshake outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_d       = col_q;
        inv_d       = inv_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    col_d      = in_data;
                    inv_d      = in_inverse;
                    cnt_d      = {CNTW{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_ISSUE;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (issue_s) begin
                    if (cnt_q == CNTW'(NBYTES - 1)) begin
                        cnt_d   = {CNTW{1'b0}};
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DRAIN: begin
                // Issue is over, so the last live tag leaving ends the column
                if (capture_s && !up_busy_s) begin
                    out_valid_d = 1'b1;
                    inv_d       = 1'b0;
                    state_d     = ST_OUT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = {CNTW{1'b0}};
                inv_d       = 1'b0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNTW{1'b0}};
            col_q       <= {CW{1'b0}};
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {CW{1'b0}};
            rnd_err_q   <= 1'b0;
            tag_v_q     <= {SBOX_LAT{1'b0}};
            for (int i = 0; i < SBOX_LAT; i++) begin
                tag_idx_q[i] <= {CNTW{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rnd_err_q   <= rnd_err_d;
            tag_v_q     <= tag_v_d;
            for (int i = 0; i < SBOX_LAT; i++) begin
                tag_idx_q[i] <= tag_idx_d[i];
            end
        end
    end

    assign in_ready      = in_ready_q;
    assign sbox_in       = sbox_in_s;
    assign sbox_in_valid = issue_s;
    assign sbox_inverse  = inv_q;
    assign rnd_ready     = issue_s | up_busy_s;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign rnd_err       = rnd_err_q;

endmodule

// File: tb/tb_msk_sbox_col_seq.sv
// ----------------------------------------------------------------------------
// tb_msk_sbox_col_seq
//   Drives msk_sbox_col_seq with directed and random columns. A behavioural
//   masked AES S-box datapath of latency LAT answers sbox_in. A
//   transaction/timestamp reference model predicts every output on each cycle.
// ----------------------------------------------------------------------------
module tb_msk_sbox_col_seq;

    localparam int D   = 2;
    localparam int LAT = 4;
    localparam int NB  = 4;
    localparam int BW  = 8 * D;
    localparam int CW  = BW * NB;

    logic          clk, rst;
    logic          in_valid, in_ready, in_inverse;
    logic [CW-1:0] in_data, out_data;
    logic [BW-1:0] sbox_in, sbox_out;
    logic          sbox_in_valid, sbox_inverse;
    logic          rnd_valid, rnd_ready;
    logic          out_valid, out_ready, rnd_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [7:0] sbox_t  [256];
    logic [7:0] isbox_t [256];

    msk_sbox_col_seq #(.d(D), .SBOX_LAT(LAT), .NBYTES(NB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse),
        .in_data(in_data),
        .sbox_in(sbox_in), .sbox_in_valid(sbox_in_valid),
        .sbox_inverse(sbox_inverse), .sbox_out(sbox_out),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rnd_err(rnd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] b, t, s;
        b = 8'h01;
        for (int i = 0; i < 254; i++) b = gmul(b, x);
        t = b; s = b;
        for (int k = 0; k < 4; k++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] unmask_byte(input logic [BW-1:0] v);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            r[j] = 1'b0;
            for (int s = 0; s < D; s++) r[j] = r[j] ^ v[D*j+s];
        end
        return r;
    endfunction

    function automatic logic [8*NB-1:0] unmask_col(input logic [CW-1:0] c);
        logic [8*NB-1:0] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = unmask_byte(c[BW*k +: BW]);
        return r;
    endfunction

    function automatic logic [BW-1:0] mask_byte(input logic [7:0] p, input bit rnd);
        logic [BW-1:0] r;
        logic acc;
        for (int j = 0; j < 8; j++) begin
            acc = p[j];
            for (int s = 0; s < D - 1; s++) begin
                r[D*j+s] = rnd ? 1'($urandom) : 1'b0;
                acc = acc ^ r[D*j+s];
            end
            r[D*j+D-1] = acc;
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] mask_col(input logic [8*NB-1:0] p, input bit rnd);
        logic [CW-1:0] r;
        for (int k = 0; k < NB; k++) r[BW*k +: BW] = mask_byte(p[8*k +: 8], rnd);
        return r;
    endfunction

    function automatic logic [BW-1:0] get_byte(input logic [CW-1:0] c, input int k);
        if (k >= 0 && k < NB) return c[BW*k +: BW];
        return '0;
    endfunction

    function automatic logic [8*NB-1:0] col_expect(input logic [8*NB-1:0] p, input bit inv);
        logic [8*NB-1:0] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = inv ? isbox_t[p[8*k +: 8]] : sbox_t[p[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural datapath ----------------
    // Slot i holds what entered i negedges ago, so the result of a byte
    // issued in cycle c is presented across the edge closing cycle c+LAT.
    bit [BW-1:0] dp [LAT+1];
    always @(negedge clk) begin
        logic [7:0] pl;
        for (int i = LAT; i > 0; i--) dp[i] = dp[i-1];
        if (sbox_in_valid === 1'b1) begin
            pl = unmask_byte(sbox_in);
            dp[0] = mask_byte(sbox_inverse ? isbox_t[pl] : sbox_t[pl], 1'b1);
        end else begin
            dp[0] = BW'($urandom);
        end
        sbox_out = dp[LAT];
    end

    // ---------------- reference model ----------------
    typedef struct packed { int due; int idx; } inf_t;
    inf_t          infl [$];
    int            cyc = 0;
    bit            m_have, m_inv, m_outp, m_err;
    int            m_issued, m_cap;
    logic [CW-1:0] m_col;
    logic [7:0]    m_out [NB];

    always @(posedge clk) begin : model
        bit acc, hs, iss;
        inf_t e;
        logic [7:0] pl;
        if (rst) begin
            m_have = 0; m_inv = 0; m_outp = 0; m_err = 0;
            m_issued = 0; m_cap = 0; m_col = '0;
            infl.delete();
            for (int k = 0; k < NB; k++) m_out[k] = 8'h00;
        end else begin
            acc = !m_have && in_valid;
            hs  = m_outp && out_ready;
            iss = m_have && (m_issued < NB) && rnd_valid;
            if (infl.size() > 0 && !rnd_valid) m_err = 1;
            if (hs) begin m_outp = 0; m_have = 0; end
            if (infl.size() > 0 && infl[0].due == cyc) begin
                pl = unmask_byte(get_byte(m_col, infl[0].idx));
                m_out[infl[0].idx] = m_inv ? isbox_t[pl] : sbox_t[pl];
                void'(infl.pop_front());
                m_cap++;
                if (m_cap == NB) m_outp = 1;
            end
            if (iss) begin
                e.due = cyc + LAT; e.idx = m_issued;
                infl.push_back(e);
                m_issued++;
            end
            if (acc) begin
                m_have = 1; m_col = in_data; m_inv = in_inverse;
                m_issued = 0; m_cap = 0;
            end
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit iss, up;
        logic [8*NB-1:0] eo;
        if (chk_en) begin
            iss = m_have && (m_issued < NB) && rnd_valid;
            up = 0;
            foreach (infl[i]) if (infl[i].due > cyc) up = 1;
            for (int k = 0; k < NB; k++) eo[8*k +: 8] = m_out[k];
            chk("in_ready", in_ready, !m_have);
            chk("out_valid", out_valid, m_outp);
            chk("sbox_in_valid", sbox_in_valid, iss);
            chk("sbox_in", sbox_in, iss ? get_byte(m_col, m_issued) : '0);
            chk("sbox_inverse", sbox_inverse, m_have && !m_outp && m_inv);
            chk("rnd_ready", rnd_ready, iss || up);
            chk("rnd_err", rnd_err, m_err);
            chk("out_data", unmask_col(out_data), eo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic accept_col(input logic [8*NB-1:0] plain, input bit inv, input bit masked);
        bit r;
        r = 0;
        in_data = mask_col(plain, masked); in_inverse = inv; in_valid = 1'b1;
        for (int n = 0; n < 40 && !r; n++) begin
            @(negedge clk);
            r = in_ready;
            tick();
        end
        if (!r) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready never seen");
        end
        in_valid = 1'b0;
        in_data = {$urandom, $urandom};
    endtask

    task automatic run_rest(input int exp_cycle, input logic [8*NB-1:0] exp_col,
                            input bit inv, input int exp_err,
                            input logic [31:0] stall, input int hold);
        int ovc, first;
        bit done;
        logic [CW-1:0] snap;
        ovc = 0; first = 0; done = 0; snap = '0;
        for (int n = 1; n <= 80 && !done; n++) begin
            rnd_valid = (n < 32) ? !stall[n] : 1'b1;
            out_ready = (ovc >= hold);
            if (ovc > 0 && ovc < hold) begin
                in_valid = 1'b1; in_data = {$urandom, $urandom}; in_inverse = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (n == 1) chk("sbox_inverse_c1", sbox_inverse, inv);
            if (out_valid) begin
                if (first == 0) begin
                    first = n; snap = out_data;
                    if (exp_cycle > 0) chk("out_cycle", n, exp_cycle);
                    chk("out_col", unmask_col(out_data), exp_col);
                    chk("sbox_inverse_out", sbox_inverse, 1'b0);
                    if (exp_err >= 0) chk("rnd_err_at_out", rnd_err, exp_err);
                end else begin
                    chk("out_hold", out_data, snap);
                    chk("in_ready_hold", in_ready, 1'b0);
                end
                if (out_ready) done = 1;
                ovc++;
            end
            tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL out_timeout: column not delivered within budget");
        end
        in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_after", in_ready, 1'b1);
        if (exp_err >= 0) chk("rnd_err_after", rnd_err, exp_err);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic [8*NB-1:0] p;
        bit inv;
        for (int x = 0; x < 256; x++) begin
            s = sbox_calc(8'(x));
            sbox_t[x] = s;
            isbox_t[s] = 8'(x);
        end
        rst = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; in_data = '0;
        rnd_valid = 1'b1; out_ready = 1'b0;

        // Model pins from hand-computed AES values
        chk("sbox_00", sbox_t[8'h00], 8'h63);
        chk("sbox_53", sbox_t[8'h53], 8'hed);
        chk("sbox_12", sbox_t[8'h12], 8'hc9);
        chk("isbox_12", isbox_t[8'h12], 8'h39);

        tick();
        chk_en = 1;
        tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rnd_err", rnd_err, 1'b0);
        chk("rst_out_data", out_data, '0);
        tick();
        rst = 1'b0;
        tick();

        // Forward and inverse columns, unmasked and masked
        accept_col(32'h1253_0100, 1'b0, 1'b0);
        run_rest(9, 32'hc9ed_7c63, 1'b0, 0, 32'h0, 0);
        accept_col(32'h12ed_7c63, 1'b1, 1'b0);
        run_rest(9, 32'h3953_0100, 1'b1, 0, 32'h0, 0);
        for (int r = 0; r < 3; r++) begin
            accept_col(32'h12ed_7c63, 1'b1, 1'b1);
            run_rest(9, 32'h3953_0100, 1'b1, 0, 32'h0, 0);
        end

        // Legal stall before any byte is in flight
        accept_col(32'h1253_0100, 1'b0, 1'b1);
        run_rest(12, 32'hc9ed_7c63, 1'b0, 0, 32'h0000_000e, 0);

        // Output back-pressure for 10 cycles with in_valid offered meanwhile
        accept_col(32'h1253_0100, 1'b0, 1'b1);
        run_rest(9, 32'hc9ed_7c63, 1'b0, 0, 32'h0, 10);

        // Starvation with two bytes in flight
        accept_col(32'h1253_0100, 1'b0, 1'b1);
        run_rest(10, 32'hc9ed_7c63, 1'b0, 1, 32'h0000_0008, 0);

        // Reset in cycle 3 of a column, then a fresh column
        accept_col(32'h1253_0100, 1'b0, 1'b1);
        rnd_valid = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst3_in_ready", in_ready, 1'b1);
        chk("rst3_out_valid", out_valid, 1'b0);
        chk("rst3_sbox_in_valid", sbox_in_valid, 1'b0);
        chk("rst3_rnd_ready", rnd_ready, 1'b0);
        chk("rst3_rnd_err", rnd_err, 1'b0);
        chk("rst3_sbox_inverse", sbox_inverse, 1'b0);
        chk("rst3_out_data", out_data, '0);
        tick();
        accept_col(32'h12ed_7c63, 1'b1, 1'b1);
        run_rest(9, 32'h3953_0100, 1'b1, 0, 32'h0, 0);

        // Random columns, randomness gaps and back-pressure
        for (int r = 0; r < 12; r++) begin
            p = $urandom;
            inv = 1'($urandom);
            accept_col(p, inv, 1'b1);
            run_rest(-1, col_expect(p, inv), inv, -1,
                     $urandom & $urandom & 32'hffff_fffe, $urandom_range(0, 3));
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
